presentation_timer_ctrl: RTL and testbench
==========================================

# presentation_timer_ctrl

Countdown controller for the presentation timer. Owns the clock divider's select input and turns the divider's output into single-cycle ticks. Runs a start/pause/stop countdown off those ticks and flags warning and expiry to the display and LED logic. Sits between the user-input debouncers and the `clock_divider` instance, in the `clk` domain.

## Interface
- `CNT_W`, 12: countdown width, in ticks.
- `DEF_SEL`, 9: divider select value driven out of reset.
- `SEL_MAX`, 25: highest legal divider select.

- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous reset, active-high.
- `start`  in  1  pulse; loads `load_val` and starts the countdown.
- `pause`  in  1  pulse; toggles between RUN and PAUSE.
- `stop`  in  1  pulse; abort and return to IDLE.
- `load_val`  in  CNT_W  countdown start value, sampled on `start`.
- `warn_thr`  in  CNT_W  warning threshold.
- `sel_req`  in  5  requested divider select.
- `sel_req_valid`  in  1  select change request.
- `sel_req_ready`  out  1  select change can be accepted.
- `div_sel`  out  5  drives the divider `sel` input.
- `div_clk`  in  1  divider `clk_out`, synchronous to `clk`.
- `tick`  out  1  one-cycle pulse per `div_clk` rising edge.
- `remaining`  out  CNT_W  ticks left.
- `state`  out  2  FSM state.
- `warn`  out  1  warning level.
- `expired`  out  1  countdown reached zero.

## Operation
- Reset values:
  - state IDLE
  - `remaining`=0
  - `div_sel`=DEF_SEL
  - `tick`=0, `warn`=0, `expired`=0
  - edge-detect history=0
- Tick generation:
  - `div_clk` is registered into `dq`; `dq` is registered into `dd`.
  - `tick` is registered as `dq & ~dd`.
  - Result: exactly one `tick` per `div_clk` rising edge.
- FSM states:
  - IDLE=0, RUN=1, PAUSE=2, EXPIRED=3.
- Priority per cycle: `stop` > `start` > `pause`.
- Transitions:
  - `stop` in any state: go to IDLE and clear `remaining`.
  - `start` in any state: load `remaining`←`load_val` and go to RUN. If `load_val`=0, go directly to EXPIRED.
  - `pause` in RUN: go to PAUSE. `pause` in PAUSE: go to RUN. `pause` is ignored in IDLE and EXPIRED.
  - `tick` in RUN: decrement `remaining`. When `remaining` goes 1→0, go to EXPIRED in the same update.
  - `tick` in IDLE, PAUSE or EXPIRED: ignored.
- Simultaneous events:
  - `tick` with `pause` in RUN: the decrement happens and the state goes to PAUSE.
  - `tick` with `stop`: `stop` wins, no decrement.
  - `tick` with `start`: reload wins.
- No wrap-around: `remaining` never decrements below 0.
- `warn` = (state RUN or PAUSE) and `remaining` ≤ `warn_thr` and `remaining` ≠ 0. Registered.
- `expired` = (state == EXPIRED). Held until `start` or `stop`.
- Select handshake:
  - `sel_req_ready` is high only in IDLE and PAUSE.
  - On `sel_req_valid & sel_req_ready`, `div_sel` ← min(`sel_req`, SEL_MAX).
  - In the same cycle, `dq` and `dd` are loaded with the current `div_clk` value, so the new rate cannot produce a spurious tick.
  - Requests while not ready are ignored. There is no queue.

## Timing
- Tick latency: `div_clk` sampled high at edge k (after sampled low at edge k-1) → `tick` high in the cycle after edge k+1, for exactly 1 cycle.
- `remaining` updates on the edge where `tick` is high, visible the next cycle.
- Control pulses (`start`/`pause`/`stop`): state and `remaining` take effect on the next edge.
- `warn` lags its condition by 1 cycle. `expired` is visible with the state change.
- Select change: `div_sel` is updated 1 cycle after the handshake. The divider registers it one further cycle.
- Reset asserted mid-countdown: all outputs return to their reset values immediately (asynchronous). Counting resumes only after a new `start`.

## Structure
- Package `ppt_pkg`:
  - FSM state encoding
  - SEL_MAX=25, DEF_SEL=9
  - CNT_W default
- Sub-module `tick_edge_detect`:
  - Contains `dq`, `dd` and the `tick` register.
  - Has a `resync` input for the select handshake.
- The FSM, countdown and handshake live in the top module.

## Test plan
- Reset, then `start` with `load_val`=3 and a `div_clk` square wave of period 8:
  - `remaining` steps 3→2→1→0, one step per tick.
  - `expired`=1 and state=3 after the third tick.
- `load_val`=10, `warn_thr`=2:
  - `warn` rises one cycle after `remaining`=2.
  - `warn` clears when `remaining`=0 and state goes to EXPIRED.
- `pause` in the same cycle as `tick` with `remaining`=5:
  - `remaining`=4, state=PAUSE.
  - Further ticks do not change `remaining`.
  - A second `pause` returns to RUN.
- `stop` coincident with `tick`, `remaining`=7: state=IDLE, `remaining`=0, no decrement.
- Select handshake:
  - In RUN, `sel_req_valid`=1 with `sel_req`=4: `sel_req_ready`=0 and `div_sel` is unchanged.
  - In PAUSE, `sel_req`=31: `div_sel`=25 one cycle later, and no tick is generated from the resync.
- Assert `rst` asynchronously mid-RUN with `remaining`=6:
  - All outputs are at reset values before the next `clk` edge.
  - `div_sel`=9.

Source files
------------

// File: rtl/ppt_pkg.sv
// Shared types and defaults for the presentation timer countdown controller.
package ppt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    localparam int CNT_W   = 12;
    localparam int DEF_SEL = 9;
    localparam int SEL_MAX = 25;

    // Saturate a requested divider select to the highest legal value.
    function automatic logic [4:0] clamp_sel(input logic [4:0] req, input logic [4:0] max_sel);
        return (req > max_sel) ? max_sel : req;
    endfunction

endpackage

// File: rtl/tick_edge_detect.sv
// Turns the divider output into one-cycle ticks; resync reloads the history so a
// rate change cannot fake an edge.
module tick_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic div_clk,
    input  logic resync,
    output logic tick
);

    logic dq_reg;
    logic dd_reg;
    logic tick_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dq_reg   <= 1'b0;
            dd_reg   <= 1'b0;
            tick_reg <= 1'b0;
        end else begin
            tick_reg <= dq_reg & ~dd_reg;
            if (resync) begin
                dq_reg <= div_clk;
                dd_reg <= div_clk;
            end else begin
                dq_reg <= div_clk;
                dd_reg <= dq_reg;
            end
        end
    end

    assign tick = tick_reg;

endmodule

// File: rtl/presentation_timer_ctrl.sv
// Start/pause/stop countdown driven by divider ticks, with warning/expiry flags
// and a ready/valid handshake for changing the divider select.
module presentation_timer_ctrl #(
    parameter int CNT_W   = ppt_pkg::CNT_W,
    parameter int DEF_SEL = ppt_pkg::DEF_SEL,
    parameter int SEL_MAX = ppt_pkg::SEL_MAX
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pause,
    input  logic             stop,
    input  logic [CNT_W-1:0] load_val,
    input  logic [CNT_W-1:0] warn_thr,
    input  logic [4:0]       sel_req,
    input  logic             sel_req_valid,
    output logic             sel_req_ready,
    output logic [4:0]       div_sel,
    input  logic             div_clk,
    output logic             tick,
    output logic [CNT_W-1:0] remaining,
    output logic [1:0]       state,
    output logic             warn,
    output logic             expired
);
    import ppt_pkg::*;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] remaining_reg, remaining_next;
    logic             warn_reg, warn_next;
    logic [4:0]       div_sel_reg;
    logic             sel_accept;

    assign sel_accept = sel_req_valid & sel_req_ready;

    tick_edge_detect u_tick (
        .clk     (clk),
        .rst     (rst),
        .div_clk (div_clk),
        .resync  (sel_accept),
        .tick    (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            remaining_reg <= '0;
            warn_reg      <= 1'b0;
            div_sel_reg   <= 5'(DEF_SEL);
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
            warn_reg      <= warn_next;
            if (sel_accept)
                div_sel_reg <= clamp_sel(sel_req, 5'(SEL_MAX));
        end
    end

    // stop > start > (tick, pause); a tick and a pause in RUN both take effect.
    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        if (stop) begin
            state_next     = ST_IDLE;
            remaining_next = '0;
        end else if (start) begin
            remaining_next = load_val;
            state_next     = (load_val == '0) ? ST_EXPIRED : ST_RUN;
        end else begin
            if (pause && state_reg == ST_RUN)
                state_next = ST_PAUSE;
            else if (pause && state_reg == ST_PAUSE)
                state_next = ST_RUN;
            if (tick && state_reg == ST_RUN && remaining_reg != '0) begin
                remaining_next = remaining_reg - CNT_W'(1);
                if (remaining_reg == CNT_W'(1))
                    state_next = ST_EXPIRED;
            end
        end
    end

    always_comb begin
        sel_req_ready = (state_reg == ST_IDLE) || (state_reg == ST_PAUSE);
        expired       = (state_reg == ST_EXPIRED);
        warn_next     = ((state_reg == ST_RUN) || (state_reg == ST_PAUSE)) &&
                        (remaining_reg <= warn_thr) && (remaining_reg != '0);
    end

    assign div_sel   = div_sel_reg;
    assign remaining = remaining_reg;
    assign state     = state_reg;
    assign warn      = warn_reg;

endmodule

// File: tb/tb_presentation_timer_ctrl.sv
// Directed bench: a per-cycle vector table for a full countdown plus hand-written
// sequences for warning, pause, stop, select handshake and async reset.
module tb_presentation_timer_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, pause, stop;
    logic [11:0] load_val, warn_thr;
    logic [4:0]  sel_req;
    logic        sel_req_valid;
    logic        sel_req_ready;
    logic [4:0]  div_sel;
    logic        div_clk;
    logic        tick;
    logic [11:0] remaining;
    logic [1:0]  state;
    logic        warn;
    logic        expired;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        start;
        logic        div_clk;
        logic [11:0] load_val;
        logic [11:0] e_rem;
        logic [1:0]  e_state;
        logic        e_tick;
        logic        e_exp;
    } vec_t;

    vec_t vecs[$];

    presentation_timer_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .pause         (pause),
        .stop          (stop),
        .load_val      (load_val),
        .warn_thr      (warn_thr),
        .sel_req       (sel_req),
        .sel_req_valid (sel_req_valid),
        .sel_req_ready (sel_req_ready),
        .div_sel       (div_sel),
        .div_clk       (div_clk),
        .tick          (tick),
        .remaining     (remaining),
        .state         (state),
        .warn          (warn),
        .expired       (expired)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    task automatic pulse_div();
        div_clk = 1'b1;
        cyc();
        div_clk = 1'b0;
        cyc();
    endtask

    task automatic pulse_tick();
        pulse_div();
        cyc();
    endtask

    task automatic add(input logic s, input logic d, input int lv, input int rem,
                       input int st, input logic tk, input logic ex);
        vec_t v;
        v.start = s; v.div_clk = d; v.load_val = 12'(lv);
        v.e_rem = 12'(rem); v.e_state = 2'(st); v.e_tick = tk; v.e_exp = ex;
        vecs.push_back(v);
    endtask

    initial begin
        rst = 1'b1; start = 0; pause = 0; stop = 0;
        load_val = '0; warn_thr = '0; sel_req = '0; sel_req_valid = 0; div_clk = 0;

        // countdown from 3 with div_clk period 8 (4 high, 4 low)
        add(1,0,3, 3,1,0,0);
        add(0,1,0, 3,1,0,0); add(0,1,0, 3,1,1,0); add(0,1,0, 2,1,0,0); add(0,1,0, 2,1,0,0);
        add(0,0,0, 2,1,0,0); add(0,0,0, 2,1,0,0); add(0,0,0, 2,1,0,0); add(0,0,0, 2,1,0,0);
        add(0,1,0, 2,1,0,0); add(0,1,0, 2,1,1,0); add(0,1,0, 1,1,0,0); add(0,1,0, 1,1,0,0);
        add(0,0,0, 1,1,0,0); add(0,0,0, 1,1,0,0); add(0,0,0, 1,1,0,0); add(0,0,0, 1,1,0,0);
        add(0,1,0, 1,1,0,0); add(0,1,0, 1,1,1,0); add(0,1,0, 0,3,0,1); add(0,1,0, 0,3,0,1);
        add(0,0,0, 0,3,0,1);

        #1;
        chk("rst_state", state, 0);
        chk("rst_remaining", remaining, 0);
        chk("rst_div_sel", div_sel, 9);
        chk("rst_tick", tick, 0);
        chk("rst_warn", warn, 0);
        chk("rst_expired", expired, 0);
        chk("rst_ready", sel_req_ready, 1);
        #11 rst = 1'b0;

        foreach (vecs[i]) begin
            start = vecs[i].start; div_clk = vecs[i].div_clk; load_val = vecs[i].load_val;
            cyc();
            start = 1'b0;
            chk($sformatf("v%0d_remaining", i), remaining, vecs[i].e_rem);
            chk($sformatf("v%0d_state", i), state, vecs[i].e_state);
            chk($sformatf("v%0d_tick", i), tick, vecs[i].e_tick);
            chk($sformatf("v%0d_expired", i), expired, vecs[i].e_exp);
            chk($sformatf("v%0d_warn", i), warn, 0);
        end

        // warning window
        stop = 1; cyc(); stop = 0;
        load_val = 10; warn_thr = 2; start = 1; cyc(); start = 0;
        chk("warn_loaded", remaining, 10);
        for (int k = 0; k < 8; k++) pulse_tick();
        chk("warn_rem2", remaining, 2);
        chk("warn_lag", warn, 0);
        cyc();
        chk("warn_rise", warn, 1);
        pulse_tick();
        chk("warn_rem1", remaining, 1);
        pulse_tick();
        chk("warn_rem0", remaining, 0);
        chk("warn_exp_state", state, 3);
        chk("warn_expired", expired, 1);
        chk("warn_still_lag", warn, 1);
        cyc();
        chk("warn_clear", warn, 0);

        // pause coincident with tick
        stop = 1; cyc(); stop = 0;
        load_val = 5; warn_thr = 0; start = 1; cyc(); start = 0;
        pulse_div();
        chk("pause_tick_present", tick, 1);
        pause = 1; cyc(); pause = 0;
        chk("pause_rem", remaining, 4);
        chk("pause_state", state, 2);
        pulse_tick(); pulse_tick();
        chk("pause_hold_rem", remaining, 4);
        chk("pause_hold_state", state, 2);

        // select change in PAUSE, clamped, with div_clk high so no edge is faked
        chk("pause_ready", sel_req_ready, 1);
        div_clk = 1; sel_req = 31; sel_req_valid = 1; cyc(); sel_req_valid = 0;
        chk("sel_clamp", div_sel, 25);
        chk("sel_tick0", tick, 0);
        cyc();
        chk("sel_tick1", tick, 0);
        cyc();
        chk("sel_tick2", tick, 0);
        div_clk = 0; cyc(); cyc();
        pause = 1; cyc(); pause = 0;
        chk("resume_state", state, 1);
        chk("resume_rem", remaining, 4);

        // select request refused in RUN
        sel_req = 4; sel_req_valid = 1;
        chk("run_ready", sel_req_ready, 0);
        cyc(); sel_req_valid = 0;
        chk("run_div_sel", div_sel, 25);

        // stop coincident with tick
        load_val = 7; start = 1; cyc(); start = 0;
        chk("stop_loaded", remaining, 7);
        pulse_div();
        chk("stop_tick_present", tick, 1);
        stop = 1; cyc(); stop = 0;
        chk("stop_state", state, 0);
        chk("stop_rem", remaining, 0);

        // start with zero load goes straight to EXPIRED
        load_val = 0; start = 1; cyc(); start = 0;
        chk("zero_state", state, 3);
        chk("zero_expired", expired, 1);

        // asynchronous reset mid-run
        load_val = 6; warn_thr = 10; start = 1; cyc(); start = 0;
        chk("arst_rem_before", remaining, 6);
        cyc();
        chk("arst_warn_before", warn, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_state", state, 0);
        chk("arst_remaining", remaining, 0);
        chk("arst_div_sel", div_sel, 9);
        chk("arst_warn", warn, 0);
        chk("arst_expired", expired, 0);
        chk("arst_tick", tick, 0);
        #2 rst = 1'b0;
        cyc();
        pulse_tick();
        chk("arst_idle_state", state, 0);
        chk("arst_idle_rem", remaining, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
